// File: rtl/slice_phase_sequencer.sv
// Slice phase sequencer: releases header, matrix, picture-header and
// per-component encoder blocks in turn, advancing on each block's done.
// Ports:
//   i_clock, i_reset                 clock, sync active-high reset
//   i_start, i_chroma_444            slice request and chroma mode
//   i_*_done                         one-cycle completion pulses
//   i_set_bit_total_byte_size        bit-packer byte count
//   o_*_reset_n                      active-low holds on sub-blocks
//   o_offset, o_block_num            current component geometry
//   o_comp_idx, o_is_y               current component
//   o_y/cb/cr/a_size, o_total_size   captured byte sizes
//   o_busy, o_done, o_timeout_err    status
module slice_phase_sequencer #(
   parameter int NUM_COMP        = 3,
   parameter int Y_BLOCKS        = 32,
   parameter int WORDS_PER_BLOCK = 64,
   parameter int TIMEOUT         = 4096
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_chroma_444,
   input  logic        i_header_done,
   input  logic        i_matrix_done,
   input  logic        i_picture_header_done,
   input  logic        i_component_done,
   input  logic [31:0] i_set_bit_total_byte_size,
   output logic        o_header_reset_n,
   output logic        o_matrix_reset_n,
   output logic        o_picture_header_reset_n,
   output logic        o_component_reset_n,
   output logic [31:0] o_offset,
   output logic [31:0] o_block_num,
   output logic [1:0]  o_comp_idx,
   output logic        o_is_y,
   output logic [31:0] o_y_size,
   output logic [31:0] o_cb_size,
   output logic [31:0] o_cr_size,
   output logic [31:0] o_a_size,
   output logic [31:0] o_total_size,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] LAST_IDX = 2'(NUM_COMP - 1);
   localparam logic [31:0] YB = 32'(Y_BLOCKS);
   localparam logic [31:0] CB_HALF = 32'(Y_BLOCKS / 2);
   localparam logic [31:0] WPB = 32'(WORDS_PER_BLOCK);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_MTX, S_PHDR, S_CGAP, S_COMP, S_FIN
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_c444;
   logic          r_hdr_rn;
   logic          r_mtx_rn;
   logic          r_phdr_rn;
   logic          r_comp_rn;
   logic [31:0]   r_offset;
   logic [31:0]   r_block_num;
   logic [1:0]    r_comp_idx;
   logic [31:0]   r_size [4];
   logic [31:0]   r_total;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic          w_wait;
   logic          w_adv;
   logic          w_expired;
   logic          w_timeout;
   logic          w_cap;
   logic [31:0]   w_size_nxt [4];
   logic [31:0]   w_sum;
   logic [1:0]    w_nxt_idx;
   logic [31:0]   w_nxt_bn;
   logic [31:0]   w_nxt_off;

   // Cb and Cr are halved in 4:2:2; Y and alpha always full size.
   function automatic logic [31:0] f_blocks(
      input logic [1:0] idx,
      input logic       c444
   );
      if ((idx == 2'd1 || idx == 2'd2) && !c444)
         return CB_HALF;
      return YB;
   endfunction

   always_comb begin
      w_wait = 1'b0;
      w_adv  = 1'b0;
      unique case (r_state)
         S_HDR:  begin w_wait = 1'b1; w_adv = i_header_done; end
         S_MTX:  begin w_wait = 1'b1; w_adv = i_matrix_done; end
         S_PHDR: begin
            w_wait = 1'b1;
            w_adv  = i_picture_header_done;
         end
         S_COMP: begin w_wait = 1'b1; w_adv = i_component_done; end
         default: begin w_wait = 1'b0; w_adv = 1'b0; end
      endcase
   end

   // A done on the expiry cycle takes priority over the timeout.
   assign w_expired = (r_cnt == CW'(TIMEOUT - 1));
   assign w_timeout = w_wait && !w_adv && w_expired;
   assign w_cap     = (r_state == S_COMP) && i_component_done;

   // Sizes including this cycle's capture, so the total is valid
   // in the same cycle as the done pulse.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_size_nxt[i] = r_size[i];
         if (w_cap && r_comp_idx == 2'(i))
            w_size_nxt[i] = i_set_bit_total_byte_size;
      end
      w_sum = w_size_nxt[0] + w_size_nxt[1]
            + w_size_nxt[2] + w_size_nxt[3];
   end

   assign w_nxt_idx = r_comp_idx + 2'd1;
   assign w_nxt_bn  = f_blocks(w_nxt_idx, r_c444);
   assign w_nxt_off = r_offset + r_block_num * WPB;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_c444      <= 1'b0;
         r_hdr_rn    <= 1'b0;
         r_mtx_rn    <= 1'b0;
         r_phdr_rn   <= 1'b0;
         r_comp_rn   <= 1'b0;
         r_offset    <= '0;
         r_block_num <= YB;
         r_comp_idx  <= '0;
         r_size      <= '{default: '0};
         r_total     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_cnt  <= r_cnt + 1'b1;
         if (w_timeout) begin
            r_state   <= S_FIN;
            r_cnt     <= '0;
            r_hdr_rn  <= 1'b0;
            r_mtx_rn  <= 1'b0;
            r_phdr_rn <= 1'b0;
            r_comp_rn <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_total   <= w_sum;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_state     <= S_HDR;
                     r_cnt       <= '0;
                     r_c444      <= i_chroma_444;
                     r_size      <= '{default: '0};
                     r_total     <= '0;
                     r_err       <= 1'b0;
                     r_comp_idx  <= '0;
                     r_offset    <= '0;
                     r_block_num <= YB;
                     r_hdr_rn    <= 1'b1;
                     r_busy      <= 1'b1;
                  end
               end
               S_HDR: begin
                  if (w_adv) begin
                     r_state  <= S_MTX;
                     r_cnt    <= '0;
                     r_hdr_rn <= 1'b0;
                     r_mtx_rn <= 1'b1;
                  end
               end
               S_MTX: begin
                  if (w_adv) begin
                     r_state   <= S_PHDR;
                     r_cnt     <= '0;
                     r_mtx_rn  <= 1'b0;
                     r_phdr_rn <= 1'b1;
                  end
               end
               S_PHDR: begin
                  if (w_adv) begin
                     r_state   <= S_CGAP;
                     r_cnt     <= '0;
                     r_phdr_rn <= 1'b0;
                  end
               end
               S_CGAP: begin
                  r_state   <= S_COMP;
                  r_cnt     <= '0;
                  r_comp_rn <= 1'b1;
               end
               S_COMP: begin
                  if (w_adv) begin
                     r_size    <= w_size_nxt;
                     r_comp_rn <= 1'b0;
                     r_cnt     <= '0;
                     if (r_comp_idx != LAST_IDX) begin
                        // Geometry moves while the block is held.
                        r_state     <= S_CGAP;
                        r_comp_idx  <= w_nxt_idx;
                        r_offset    <= w_nxt_off;
                        r_block_num <= w_nxt_bn;
                     end else begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_total <= w_sum;
                     end
                  end
               end
               S_FIN: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign o_header_reset_n         = r_hdr_rn;
   assign o_matrix_reset_n         = r_mtx_rn;
   assign o_picture_header_reset_n = r_phdr_rn;
   assign o_component_reset_n      = r_comp_rn;
   assign o_offset                 = r_offset;
   assign o_block_num              = r_block_num;
   assign o_comp_idx               = r_comp_idx;
   assign o_is_y                   = (r_comp_idx == 2'd0);
   assign o_y_size                 = r_size[0];
   assign o_cb_size                = r_size[1];
   assign o_cr_size                = r_size[2];
   assign o_a_size                 = r_size[3];
   assign o_total_size             = r_total;
   assign o_busy                   = r_busy;
   assign o_done                   = r_done;
   assign o_timeout_err            = r_err;

endmodule
